alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_driver.sv | 120 ++++++++++++
 tb/tb_alu_driver.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the driver FSM state type.
// Imported by alu_driver and anything that talks to the ALU.
package alu_pkg;

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] AND = 4'b0010;
    localparam logic [3:0] OR  = 4'b0011;
    localparam logic [3:0] XOR = 4'b0100;
    localparam logic [3:0] EQ  = 4'b0101;
    localparam logic [3:0] SGE = 4'b0110;
    localparam logic [3:0] SRL = 4'b0111;
    localparam logic [3:0] SLL = 4'b1000;
    localparam logic [3:0] MUL = 4'b1001;
    localparam logic [3:0] DIV = 4'b1010;

    // Highest opcode the ALU implements; anything above is rejected.
    localparam logic [3:0] MODE_MAX = DIV;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } drv_state_t;

endpackage

// File: rtl/alu_driver.sv
// One-outstanding-command driver between a cmd stream, the ALU and a rsp stream.
// Optional ALU_DRIVER_TIMEOUT_EN adds a wait watchdog that answers with rsp_err.
module alu_driver
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_mode,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        alu_valid,
    output logic [3:0]  alu_mode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic        alu_ready,
    input  logic [63:0] alu_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_err
);

    drv_state_t state;

    // The watchdog compares against TIMEOUT-1, so fewer than 2 is meaningless.
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("alu_driver: TIMEOUT must be at least 2");
    end

`ifdef ALU_DRIVER_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wait_cnt;
`endif

    // Command FSM; every output is a flop so the ALU sees glitch-free operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            alu_valid <= 1'b0;
            alu_mode  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
`ifdef ALU_DRIVER_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            alu_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_mode <= MODE_MAX) begin
                            alu_mode  <= cmd_mode;
                            alu_a     <= cmd_a;
                            alu_b     <= cmd_b;
                            alu_valid <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ISSUE: begin
`ifdef ALU_DRIVER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    if (alu_ready) begin
                        rsp_data  <= alu_data;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (alu_ready) begin
                        rsp_data  <= alu_data;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
`ifdef ALU_DRIVER_TIMEOUT_EN
                    else if (wait_cnt == LAST) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver: directed vector table, hand-written
// reset/stale-ready sequences, and randomized commands against an ALU model.
module tb_alu_driver;
    import alu_pkg::*;

`ifdef ALU_DRIVER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif
    localparam int NEVER = 1000;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_mode;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        alu_valid;
    logic [3:0]  alu_mode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_ready;
    logic [63:0] alu_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;

    int n_total = 0;
    int n_pass  = 0;

    alu_driver #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_valid (alu_valid),
        .alu_mode  (alu_mode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ready (alu_ready),
        .alu_data  (alu_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          hold;
        logic [63:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // What a correct ALU returns for each opcode.
    function automatic logic [63:0] alu_ref(input logic [3:0] m,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] r;
        r = '0;
        case (m)
            ADD: r = {32'h0, a + b};
            SUB: r = {32'h0, a - b};
            AND: r = {32'h0, a & b};
            OR:  r = {32'h0, a | b};
            XOR: r = {32'h0, a ^ b};
            EQ:  r = {63'h0, a == b};
            SGE: r = {63'h0, $signed(a) >= $signed(b)};
            SRL: r = {32'h0, a >> b[4:0]};
            SLL: r = {32'h0, a << b[4:0]};
            MUL: r = 64'(a) * 64'(b);
            DIV: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] outs_packed();
        return {60'h0, cmd_ready, alu_valid, rsp_valid, rsp_err}
             | {28'h0, alu_mode, alu_a}
             | {32'h0, alu_b}
             | rsp_data;
    endfunction

    // Drive one command through the DUT, acting as ALU and response sink.
    task automatic run_cmd(input vec_t v, input string tag);
        int          cyc;
        int          n_issue;
        int          ready_at;
        int          wc;
        bit          stable_ok;
        bit          hold_ok;
        logic [63:0] got_data;
        logic        got_err;
        bit          legal;

        legal = (v.mode <= MODE_MAX);
`ifdef ALU_DRIVER_TIMEOUT_EN
        if (legal && v.lat > TO) begin
            v.exp_data = '0;
            v.exp_err  = 1'b1;
            v.exp_lat  = TO + 2;
        end
`endif
        wc = 0;
        while (!cmd_ready && wc < 10) begin
            step();
            wc++;
        end
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);

        cmd_valid = 1'b1;
        cmd_mode  = v.mode;
        cmd_a     = v.a;
        cmd_b     = v.b;
        step();
        cmd_valid = 1'b0;
        cmd_mode  = 4'($urandom);
        cmd_a     = $urandom;
        cmd_b     = $urandom;

        cyc       = 1;
        n_issue   = 0;
        ready_at  = -1;
        stable_ok = 1'b1;
        while (!rsp_valid && cyc < 200) begin
            if (alu_valid) begin
                n_issue++;
                ready_at = cyc + v.lat;
            end
            if (cmd_ready) stable_ok = 1'b0;
            if (n_issue > 0 &&
                {alu_mode, alu_a, alu_b} !== {v.mode, v.a, v.b})
                stable_ok = 1'b0;
            alu_ready = (n_issue > 0 && cyc == ready_at);
            alu_data  = alu_ready ? alu_ref(alu_mode, alu_a, alu_b)
                                  : {$urandom, $urandom};
            step();
            alu_ready = 1'b0;
            cyc++;
        end

        check({tag, "_issue_cnt"}, 64'(n_issue), legal ? 64'd1 : 64'd0);
        check({tag, "_ops_stable"}, 64'(stable_ok), 64'd1);
        check({tag, "_latency"}, 64'(cyc), 64'(v.exp_lat));
        check({tag, "_rsp_data"}, rsp_data, v.exp_data);
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'(v.exp_err));

        got_data = rsp_data;
        got_err  = rsp_err;
        hold_ok  = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            if (!(rsp_valid && rsp_data === got_data && rsp_err === got_err
                  && !cmd_ready && !alu_valid))
                hold_ok = 1'b0;
            alu_ready = (h == 0);
            alu_data  = {$urandom, $urandom};
            step();
            alu_ready = 1'b0;
        end
        if (!(rsp_valid && rsp_data === got_data && rsp_err === got_err
              && !cmd_ready))
            hold_ok = 1'b0;
        check({tag, "_hold"}, 64'(hold_ok), 64'd1);

        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_release"}, {62'h0, rsp_valid, cmd_ready}, 64'b01);
    endtask

    initial begin
        vec_t v;
        bit   seen;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        alu_ready = 1'b0;
        alu_data  = '0;
        rsp_ready = 1'b0;

        // mode, a, b, alu latency, rsp_ready-low cycles, data, err, latency
        tbl.push_back('{ADD, 32'd5, 32'd7, 1, 0,
                        64'h0000_0000_0000_000C, 1'b0, 3});
        tbl.push_back('{MUL, 32'h0001_0000, 32'h0001_0000, 33, 0,
                        64'h0000_0001_0000_0000, 1'b0, 35});
        tbl.push_back('{DIV, 32'd100, 32'd7, 33, 5,
                        64'h0000_0002_0000_000E, 1'b0, 35});
        tbl.push_back('{4'b1111, 32'd9, 32'd3, 1, 3,
                        64'h0, 1'b1, 1});
        tbl.push_back('{4'b1011, 32'd1, 32'd1, 1, 0,
                        64'h0, 1'b1, 1});
        tbl.push_back('{SUB, 32'd3, 32'd5, 0, 1,
                        64'h0000_0000_FFFF_FFFE, 1'b0, 2});
        tbl.push_back('{SGE, 32'hFFFF_FFFF, 32'd1, 2, 0,
                        64'h0, 1'b0, 4});
        tbl.push_back('{SLL, 32'h8000_0001, 32'd4, 1, 2,
                        64'h0000_0000_0000_0010, 1'b0, 3});
`ifdef ALU_DRIVER_TIMEOUT_EN
        tbl.push_back('{ADD, 32'd1, 32'd2, NEVER, 3,
                        64'h0, 1'b1, TO + 2});
`endif

        step();
        step();
        check("reset_outputs", outs_packed(), 64'h0);
        rst = 1'b0;
        step();
        check("post_reset_ready", 64'(cmd_ready), 64'd1);

        foreach (tbl[i]) run_cmd(tbl[i], $sformatf("vec%0d", i));

        // A stray alu_ready while idle must not make a response.
        alu_ready = 1'b1;
        alu_data  = 64'hDEAD_BEEF_0000_0001;
        step();
        alu_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid || !cmd_ready) seen = 1'b1;
            step();
        end
        check("idle_stale_ready", 64'(seen), 64'd0);

        // Reset in the middle of a long MUL wait.
        cmd_valid = 1'b1;
        cmd_mode  = MUL;
        cmd_a     = 32'h1234_5678;
        cmd_b     = 32'h9;
        step();
        cmd_valid = 1'b0;
        check("rst_mul_issue", 64'(alu_valid), 64'd1);
        for (int i = 0; i < 5; i++) step();
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_zero", outs_packed(), 64'h0);
        step();
        step();
        check("rst_held_zero", outs_packed(), 64'h0);
        rst = 1'b0;
        step();
        check("rst_release_ready", 64'(cmd_ready), 64'd1);
        alu_ready = 1'b1;
        alu_data  = 64'h1;
        step();
        alu_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid || alu_valid) seen = 1'b1;
            step();
        end
        check("rst_dropped", 64'(seen), 64'd0);

        // Random commands against the reference ALU.
        for (int i = 0; i < 40; i++) begin
            v.mode = 4'($urandom_range(0, 15));
            v.a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9))
                                                 : $urandom;
            v.b    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9))
                                                 : $urandom;
            v.lat  = $urandom_range(0, 6);
            v.hold = $urandom_range(0, 3);
            if (v.mode <= MODE_MAX) begin
                v.exp_data = alu_ref(v.mode, v.a, v.b);
                v.exp_err  = 1'b0;
                v.exp_lat  = 2 + v.lat;
            end else begin
                v.exp_data = '0;
                v.exp_err  = 1'b1;
                v.exp_lat  = 1;
            end
            run_cmd(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
